// File: rtl/bus_master_8088_if.sv
// Host request/response and 8088 bus control pins of the bus master.
// AD is kept outside the interface so it resolves as a true tristate net.
interface bus_master_8088_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 20
);
    logic                              req;
    logic                              we;
    logic                              iom;
    logic [ADDRESS_WIDTH-1:0]          addr;
    logic [DATA_WIDTH-1:0]             wdata;
    logic [DATA_WIDTH-1:0]             rdata;
    logic                              busy;
    logic                              done;
    logic                              err;
    logic [ADDRESS_WIDTH-DATA_WIDTH-1:0] A;
    logic                              ALE;
    logic                              RD;
    logic                              WR;
    logic                              IOM;
    logic                              DTR;
    logic                              DEN;
    logic                              READY;

    modport master (
        input  req, we, iom, addr, wdata, READY,
        output rdata, busy, done, err, A, ALE, RD, WR, IOM, DTR, DEN
    );
    modport slave (
        output req, we, iom, addr, wdata, READY,
        input  rdata, busy, done, err, A, ALE, RD, WR, IOM, DTR, DEN
    );
endinterface

// File: rtl/bus_master_8088.sv
// 8088 minimum-mode bus initiator: turns single host transfers into
// T1-T2-T3-(Tw)-T4 cycles with READY wait states and a wait-limit abort.
module bus_master_8088 #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 20,
    parameter int MAX_WAIT      = 15
) (
    input  logic                  CLK,
    input  logic                  RESET,
    bus_master_8088_if.master     bus,
    inout  wire  [DATA_WIDTH-1:0] AD
);
    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        T1   = 6'b000010,
        T2   = 6'b000100,
        T3   = 6'b001000,
        TW   = 6'b010000,
        T4   = 6'b100000
    } state_t;

    state_t                state;
    logic                  c_we;
    logic [DATA_WIDTH-1:0] c_wdata;
    logic [CW-1:0]         wait_cnt;
    logic                  ad_oe;
    logic [DATA_WIDTH-1:0] ad_out;
    logic                  end_wait;

    assign AD = ad_oe ? ad_out : {DATA_WIDTH{1'bz}};

    // T3/TW ends either on READY or when the wait budget is exhausted
    assign end_wait = bus.READY || (wait_cnt == CW'(MAX_WAIT));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            c_we      <= 1'b0;
            c_wdata   <= '0;
            wait_cnt  <= '0;
            ad_oe     <= 1'b0;
            ad_out    <= '0;
            bus.rdata <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.err   <= 1'b0;
            bus.A     <= '0;
            bus.ALE   <= 1'b0;
            bus.RD    <= 1'b1;
            bus.WR    <= 1'b1;
            bus.IOM   <= 1'b0;
            bus.DTR   <= 1'b1;
            bus.DEN   <= 1'b1;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                T1: begin
                    state   <= T2;
                    bus.ALE <= 1'b0;
                    bus.DEN <= 1'b0;
                    if (c_we) begin
                        bus.WR <= 1'b0;
                        ad_out <= c_wdata;
                    end else begin
                        bus.RD <= 1'b0;
                        ad_oe  <= 1'b0;
                    end
                end
                T2: state <= T3;
                T3, TW: begin
                    if (end_wait) begin
                        if (bus.READY && !c_we) bus.rdata <= AD;
                        state    <= T4;
                        bus.RD   <= 1'b1;
                        bus.WR   <= 1'b1;
                        bus.DEN  <= 1'b1;
                        ad_oe    <= 1'b0;
                        bus.done <= 1'b1;
                        bus.err  <= !bus.READY;
                        wait_cnt <= '0;
                    end else begin
                        state    <= TW;
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    // IDLE and T4 both accept a request; T4 chains back-to-back
                    if (bus.req) begin
                        state    <= T1;
                        bus.busy <= 1'b1;
                        c_we     <= bus.we;
                        c_wdata  <= bus.wdata;
                        ad_oe    <= 1'b1;
                        ad_out   <= bus.addr[DATA_WIDTH-1:0];
                        bus.A    <= bus.addr[ADDRESS_WIDTH-1:DATA_WIDTH];
                        bus.ALE  <= 1'b1;
                        bus.IOM  <= bus.iom;
                        bus.DTR  <= bus.we;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/bus_master_8088.md
Name: bus_master_8088

Overview:
- Initiator end of the 8088 minimum-mode bus. It converts single host transfer requests into T1-T2-T3-(Tw)-T4 bus cycles.
- It drives the multiplexed address/data bus, ALE, RD, WR and IOM that the memory and IO peripherals decode.
- It inserts wait states on READY and returns read data to the host with a done pulse.
- It sits between the test driver/CPU model and the peripheral array on the shared Intel8088Pins bus.

Parameters:
- DATA_WIDTH, 8, width of AD data lanes and host data.
- ADDRESS_WIDTH, 20, full physical address width; AD carries bits [DATA_WIDTH-1:0], A carries the rest.
- MAX_WAIT, 15, maximum consecutive Tw states before the cycle is aborted with err.

Ports:
- CLK  input  1  bus clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset (asserted when 0).
- req  input  1  host request; sampled only in IDLE or T4.
- we  input  1  1 = write, 0 = read; captured with req.
- iom  input  1  1 = IO space, 0 = memory space; captured with req.
- addr  input  ADDRESS_WIDTH  transfer address; captured with req.
- wdata  input  DATA_WIDTH  write data; captured with req.
- rdata  output  DATA_WIDTH  read data; valid from the done cycle until the next read completes.
- busy  output  1  high from the capture edge through T4.
- done  output  1  one-cycle pulse in T4.
- err  output  1  one-cycle pulse in T4 when the cycle was aborted by MAX_WAIT.
- AD  inout  DATA_WIDTH  multiplexed address/data bus.
- A  output  ADDRESS_WIDTH-DATA_WIDTH  upper address bits.
- ALE  output  1  address latch enable, active high.
- RD  output  1  read strobe, active low.
- WR  output  1  write strobe, active low.
- IOM  output  1  IO/memory select.
- DTR  output  1  1 = transmit (write), 0 = receive (read).
- DEN  output  1  data enable, active low.
- READY  input  1  1 = peripheral ready; 0 = insert a wait state.

Behaviour:
- States: IDLE, T1, T2, T3, TW, T4 (one-hot). Reset state is IDLE.
- Reset values: RD=1, WR=1, ALE=0, DEN=1, DTR=1, IOM=0, A=0, AD=high-z, busy=0, done=0, err=0, rdata=0, wait counter=0. All outputs are registered.
- Reset mid-cycle: aborts immediately to IDLE with the reset values. No done or err is generated.
- IDLE:
  - req=1 at an edge captures we, iom, addr and wdata into internal registers. busy rises and the next state is T1.
  - req is ignored in T1 through TW.
- T1:
  - ALE=1.
  - AD drives addr[DATA_WIDTH-1:0]; A drives addr[ADDRESS_WIDTH-1:DATA_WIDTH].
  - IOM=iom and DTR=we. RD, WR and DEN stay inactive.
- T2:
  - ALE=0; A and IOM hold.
  - Read: RD=0, AD released to high-z, DEN=0.
  - Write: WR=0, AD drives wdata, DEN=0.
  - Next state is T3 unconditionally.
- T3 and TW:
  - Strobes, DEN and write data hold.
  - READY is sampled at the rising edge that ends the state.
  - READY=1: for a read, rdata <= AD. Next state is T4.
  - READY=0: next state is TW and the wait counter increments.
  - When the wait counter reaches MAX_WAIT with READY still 0, go to T4 with the abort flag set; rdata is left unchanged.
- T4:
  - RD=1, WR=1, DEN=1, AD=high-z, ALE=0.
  - done=1. err=1 only if the cycle was aborted.
  - The wait counter clears.
  - req=1 in T4: capture the new request and go directly to T1 (back-to-back cycle, busy stays 1).
  - req=0 in T4: go to IDLE and busy falls.
- Latency: zero-wait cycle is capture edge, then T1, T2, T3, T4, so done appears in the 4th cycle after capture. Each wait state adds one cycle.
- Bus contention: AD is never driven during T2 through T4 of a read.
- Strobe exclusivity: RD and WR are never low simultaneously. ALE is never high while RD=0 or WR=0.
- MAX_WAIT=0 means any READY=0 sample in T3 aborts immediately.
- Host inputs changing after capture have no effect on the cycle in progress.

Test Plan:
- Memory read, READY=1, iom=0, addr=20'h0_0012:
  - T1: ALE=1, AD=8'h12, A=12'h000, IOM=0.
  - Slave returns 8'hA5 in T3.
  - rdata=8'hA5 with done in the 4th cycle after capture; RD low only in T2/T3.
- IO write, iom=1, addr=20'h0_1C40, wdata=8'h3C:
  - A=12'h01C, AD=8'h40 in T1, then AD=8'h3C in T2-T3.
  - WR=0 in T2-T3, DTR=1, IOM=1; the slave memory location 16'h1C40 reads back 8'h3C.
- Read with READY=0 for 3 T3/TW samples:
  - Exactly 3 TW states; done in the 7th cycle after capture; RD held low throughout.
- READY held 0, MAX_WAIT=15:
  - After 15 TW, T4 with done=1 and err=1; rdata keeps its previous value; strobes released.
- Back-to-back: req held 1 with a write then a read:
  - T4 of the write is followed directly by T1 of the read; busy never drops; two done pulses 4 cycles apart.
- RESET driven 0 during T3 of a write:
  - WR=1, DEN=1, AD=high-z and busy=0 before the next edge.
  - No done pulse; after release the FSM stays in IDLE until req.
